// File: rtl/rom_digest_rx.sv
// -----------------------------------------------------------------------------
// rom_digest_rx
//
// Key-manager-side receiver for the ROM controller digest and ROM check status.
// The block captures the 256-bit digest when the ROM controller marks it valid.
// It then requires StableCycles consecutive cycles of done&good with unchanged
// data before it presents the digest as qualified. Any protocol violation puts
// the block in an Error state. Only a reset leaves that state.
//
// Optional feature (macro ROM_DIGEST_RX_TIMEOUT_EN):
//   When defined, a saturating timeout counter limits the time from reset
//   release to Ready. On expiry the block raises error code 1. When the macro
//   is undefined, Idle and Settle wait indefinitely.
//
// Parameters:
//   StableCycles   settle length in done&good cycles (>= 1)
//   TimeoutCycles  maximum cycles from reset release to Ready (>= 2)
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   rom_data_i      ROM digest (keymgr data field)
//   rom_valid_i     ROM digest valid
//   rom_done_i      ROM check done
//   rom_good_i      ROM check passed
//   digest_o        qualified digest, zero unless in Ready
//   digest_valid_o  high only in Ready
//   err_o           high only in Error
//   err_code_o      0 none, 1 timeout, 2 unstable, 3 bad ROM
// -----------------------------------------------------------------------------
module rom_digest_rx #(
   parameter int StableCycles  = 2,
   parameter int TimeoutCycles = 1024
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [255:0] rom_data_i,
   input  logic         rom_valid_i,
   input  logic         rom_done_i,
   input  logic         rom_good_i,
   output logic [255:0] digest_o,
   output logic         digest_valid_o,
   output logic         err_o,
   output logic [1:0]   err_code_o
);

   localparam int StW = $clog2(StableCycles + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_READY,
      ST_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_UNSTABLE = 2'd2;
   localparam logic [1:0] ERR_BAD_ROM  = 2'd3;

   if (StableCycles < 1 || TimeoutCycles < 2) begin : g_bad_param
      $error("rom_digest_rx: StableCycles must be >= 1 and TimeoutCycles >= 2");
   end

   state_t         r_state, w_state_nxt;
   logic [255:0]   r_capture, w_capture_nxt;
   logic [StW-1:0] r_stable, w_stable_nxt;
   logic [1:0]     r_err_code, w_err_code_nxt;

   logic w_bad_rom;
   logic w_unstable;
   logic w_timeout_hit;

   // The ROM reports a finished check that failed.
   assign w_bad_rom  = rom_done_i & ~rom_good_i;
   // The digest disappeared or changed after capture.
   assign w_unstable = ~rom_valid_i | (rom_data_i != r_capture);

`ifdef ROM_DIGEST_RX_TIMEOUT_EN
   localparam int ToW = $clog2(TimeoutCycles + 1);

   logic [ToW-1:0] r_timeout;

   // The count saturates at TimeoutCycles and never wraps. A block that sits in
   // Error for a long time therefore cannot produce a false expiry later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_timeout <= '0;
      end else if ((r_state == ST_IDLE || r_state == ST_SETTLE) &&
                   r_timeout != ToW'(TimeoutCycles)) begin
         r_timeout <= r_timeout + ToW'(1);
      end
   end

   assign w_timeout_hit = (r_state == ST_IDLE || r_state == ST_SETTLE) &&
                          (r_timeout == ToW'(TimeoutCycles - 1));
`else
   assign w_timeout_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge. Ordering inside the block then
   // does not matter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_capture  <= '0;
         r_stable   <= '0;
         r_err_code <= ERR_NONE;
      end else begin
         r_state    <= w_state_nxt;
         r_capture  <= w_capture_nxt;
         r_stable   <= w_stable_nxt;
         r_err_code <= w_err_code_nxt;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_capture_nxt  = r_capture;
      w_stable_nxt   = r_stable;
      w_err_code_nxt = r_err_code;

      unique case (r_state)
         ST_IDLE: begin
            if (w_bad_rom) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_BAD_ROM;
            end else if (w_timeout_hit) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_TIMEOUT;
            end else if (rom_valid_i) begin
               w_state_nxt   = ST_SETTLE;
               w_capture_nxt = rom_data_i;
               w_stable_nxt  = '0;
            end
         end

         ST_SETTLE: begin
            if (w_bad_rom) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_BAD_ROM;
            end else if (w_unstable) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_UNSTABLE;
            end else if (rom_done_i) begin
               // done & good (done & !good is handled above as bad ROM).
               // Reaching Ready on the expiry edge beats the timeout.
               if (r_stable == StW'(StableCycles - 1)) begin
                  w_state_nxt = ST_READY;
               end else if (w_timeout_hit) begin
                  w_state_nxt    = ST_ERROR;
                  w_err_code_nxt = ERR_TIMEOUT;
               end else begin
                  w_stable_nxt = r_stable + StW'(1);
               end
            end else if (w_timeout_hit) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_TIMEOUT;
            end else begin
               w_stable_nxt = '0;
            end
         end

         ST_READY: begin
            if (w_bad_rom) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_BAD_ROM;
            end else if (w_unstable || !rom_done_i) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_UNSTABLE;
            end
         end

         ST_ERROR: begin
            // Sticky until reset.
         end

         default: begin
            w_state_nxt = ST_ERROR;
         end
      endcase
   end

   assign digest_valid_o = (r_state == ST_READY);
   assign digest_o       = digest_valid_o ? r_capture : '0;
   assign err_o          = (r_state == ST_ERROR);
   assign err_code_o     = r_err_code;

endmodule

// File: tb/tb_rom_digest_rx.sv
// -----------------------------------------------------------------------------
// tb_rom_digest_rx
//
// Scoreboard bench for rom_digest_rx with StableCycles=2 and TimeoutCycles=16.
// Each stimulus step pushes the output expected after the next clock edge.
// The step then pops that entry once the DUT has updated and compares it.
// Build with or without ROM_DIGEST_RX_TIMEOUT_EN. The timeout scenarios select
// their expectations from the same macro.
// -----------------------------------------------------------------------------
module tb_rom_digest_rx;

   localparam int StableCycles  = 2;
   localparam int TimeoutCycles = 16;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [255:0] rom_data_i = '0;
   logic         rom_valid_i = 1'b0;
   logic         rom_done_i = 1'b0;
   logic         rom_good_i = 1'b0;
   logic [255:0] digest_o;
   logic         digest_valid_o;
   logic         err_o;
   logic [1:0]   err_code_o;

   rom_digest_rx #(
      .StableCycles (StableCycles),
      .TimeoutCycles(TimeoutCycles)
   ) u_dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rom_data_i    (rom_data_i),
      .rom_valid_i   (rom_valid_i),
      .rom_done_i    (rom_done_i),
      .rom_good_i    (rom_good_i),
      .digest_o      (digest_o),
      .digest_valid_o(digest_valid_o),
      .err_o         (err_o),
      .err_code_o    (err_code_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string        tag;
      logic [255:0] digest;
      logic         dv;
      logic         err;
      logic [1:0]   code;
   } exp_t;

   exp_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [255:0] d_a5;
   logic [255:0] d_b;
   logic [255:0] d_one;
   logic [255:0] d_tmp;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [255:0] dig,
                           input logic dv, input logic err,
                           input logic [1:0] code);
      exp_t e;
      e.tag = tag; e.digest = dig; e.dv = dv; e.err = err; e.code = code;
      q_exp.push_back(e);
   endtask

   task automatic pop_and_compare();
      exp_t e;
      if (q_exp.size() == 0) begin
         check("scoreboard_empty", 256'd1, 256'd0);
      end else begin
         e = q_exp.pop_front();
         check({e.tag, ".digest"}, digest_o, e.digest);
         check({e.tag, ".valid"}, 256'(digest_valid_o), 256'(e.dv));
         check({e.tag, ".err"}, 256'(err_o), 256'(e.err));
         check({e.tag, ".code"}, 256'(err_code_o), 256'(e.code));
      end
   endtask

   // Drive inputs, push the state expected after the next edge, then wait for
   // that edge and compare 1 ns later.
   task automatic step(input string tag, input logic [255:0] d, input logic v,
                       input logic dn, input logic g,
                       input logic [255:0] e_dig, input logic e_dv,
                       input logic e_err, input logic [1:0] e_code);
      rom_data_i  = d;
      rom_valid_i = v;
      rom_done_i  = dn;
      rom_good_i  = g;
      push_exp(tag, e_dig, e_dv, e_err, e_code);
      @(posedge clk_i);
      #1;
      pop_and_compare();
   endtask

   // Assert reset away from a clock edge and check that the outputs clear at
   // once. Release it 1 ns after an edge, so the next edge is edge 1.
   task automatic do_reset(input string tag);
      rst_i       = 1'b1;
      rom_data_i  = '0;
      rom_valid_i = 1'b0;
      rom_done_i  = 1'b0;
      rom_good_i  = 1'b0;
      #1;
      push_exp(tag, '0, 1'b0, 1'b0, 2'd0);
      pop_and_compare();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      d_a5  = {32{8'hA5}};
      d_b   = {8{32'hDEADBEEF}};
      d_one = 256'h1;

      // Best-case qualification of the A5 pattern.
      do_reset("rst0");
      step("t1_e1", d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t1_e2", d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t1_e3", d_a5, 1, 1, 1, d_a5, 1, 0, 2'd0);
      step("t1_e4", d_a5, 1, 1, 1, d_a5, 1, 0, 2'd0);
      // Dropping valid in Ready causes an unstable error. The error stays
      // after valid returns.
      step("t5_drop", d_a5, 0, 1, 1, '0, 0, 1, 2'd2);
      step("t5_sticky", d_a5, 1, 1, 1, '0, 0, 1, 2'd2);

      // Reset while in Ready: digest clears immediately.
      do_reset("rst_from_err");
      step("t1b_e1", d_b, 1, 1, 1, '0,  0, 0, 2'd0);
      step("t1b_e2", d_b, 1, 1, 1, '0,  0, 0, 2'd0);
      step("t1b_e3", d_b, 1, 1, 1, d_b, 1, 0, 2'd0);
      do_reset("rst_from_ready");

      // Data bit 0 flips in Settle; restoring the data does not clear the error.
      d_tmp = d_b ^ 256'h1;
      step("t2_cap",  d_b,   1, 1, 1, '0, 0, 0, 2'd0);
      step("t2_flip", d_tmp, 1, 1, 1, '0, 0, 1, 2'd2);
      step("t2_rest", d_b,   1, 1, 1, '0, 0, 1, 2'd2);

      // Bad ROM in Idle.
      do_reset("rst2");
      step("t3_bad_idle", d_b, 1, 1, 0, '0, 0, 1, 2'd3);
      // Bad ROM and a data change together in Settle: bad ROM wins.
      do_reset("rst3");
      step("t3_cap", d_b, 1, 1, 1, '0, 0, 0, 2'd0);
      step("t3_prio", d_tmp, 1, 1, 0, '0, 0, 1, 2'd3);

      // done drops while in Ready.
      do_reset("rst4");
      step("t5b_e1", d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t5b_e2", d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t5b_e3", d_a5, 1, 1, 1, d_a5, 1, 0, 2'd0);
      step("t5b_nodone", d_a5, 1, 0, 1, '0, 0, 1, 2'd2);

      // done low in Settle clears the stable count, so the settle restarts.
      do_reset("rst5");
      step("t7_cap", d_b, 1, 1, 1, '0,  0, 0, 2'd0);
      step("t7_s1",  d_b, 1, 1, 1, '0,  0, 0, 2'd0);
      step("t7_clr", d_b, 1, 0, 0, '0,  0, 0, 2'd0);
      step("t7_s1b", d_b, 1, 1, 1, '0,  0, 0, 2'd0);
      step("t7_rdy", d_b, 1, 1, 1, d_b, 1, 0, 2'd0);

      // Timeout behaviour.
      do_reset("rst6");
`ifdef ROM_DIGEST_RX_TIMEOUT_EN
      for (int i = 1; i < TimeoutCycles; i++) begin
         step("t4_wait", '0, 0, 0, 0, '0, 0, 0, 2'd0);
      end
      step("t4_expire", '0, 0, 0, 0, '0, 0, 1, 2'd1);
      step("t4_sticky", d_a5, 1, 1, 1, '0, 0, 1, 2'd1);
      // Entering Ready on the expiry edge beats the timeout.
      do_reset("rst7");
      for (int i = 1; i <= TimeoutCycles - 3; i++) begin
         step("t4b_wait", '0, 0, 0, 0, '0, 0, 0, 2'd0);
      end
      step("t4b_cap", d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t4b_s1",  d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t4b_rdy", d_a5, 1, 1, 1, d_a5, 1, 0, 2'd0);
      step("t4b_hold", d_a5, 1, 1, 1, d_a5, 1, 0, 2'd0);
`else
      for (int i = 1; i <= 1000; i++) begin
         step("t4_idle", '0, 0, 0, 0, '0, 0, 0, 2'd0);
      end
      step("t4_cap", d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t4_s1",  d_a5, 1, 1, 1, '0,   0, 0, 2'd0);
      step("t4_rdy", d_a5, 1, 1, 1, d_a5, 1, 0, 2'd0);
`endif

      // Reset mid-Settle, then capture and qualify a new digest.
      do_reset("rst8");
      step("t6_cap", d_b, 1, 1, 1, '0, 0, 0, 2'd0);
      step("t6_s1",  d_b, 1, 1, 1, '0, 0, 0, 2'd0);
      do_reset("t6_rst_mid");
      step("t6_e1", d_one, 1, 1, 1, '0,    0, 0, 2'd0);
      step("t6_e2", d_one, 1, 1, 1, '0,    0, 0, 2'd0);
      step("t6_e3", d_one, 1, 1, 1, d_one, 1, 0, 2'd0);

      check("scoreboard_drained", 256'(q_exp.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
